// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Row k of the stimulus maps to code bit 7-k.
package truth_table_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int N_IN   = 3;
    localparam int N_ROWS = 8;

    function automatic logic [2:0] row_bit(input logic [2:0] k);
        return 3'(N_ROWS - 1) - k;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle counter: holds each stimulus row for SETTLE_CYCLES.
// tc flags the last settle cycle; the count parks there until reloaded.
module settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == CNT_W'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (enable && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 8 rows of a 3-input gate, captures its truth-table
// code and compares it against a latched expected code.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic [2:0] stim,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic [7:0] observed,
    output logic       pass,
    output logic [7:0] mismatch
);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] idx_q;
    logic [7:0] exp_q;
    logic [7:0] obs_q;
    logic       valid_q;
    logic       pass_q;
    logic [7:0] mis_q;

    logic       tmr_load;
    logic       tmr_en;
    logic       tmr_tc;
    logic       accept;
    logic       last_row;

    assign last_row = (idx_q == 3'(N_ROWS - 1));

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .enable(tmr_en),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    tmr_load = 1'b1;
                    accept   = 1'b1;
                end
            end
            SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (last_row) begin
                    state_d = DONE;
                end else begin
                    state_d  = SETTLE;
                    tmr_load = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // abort overrides every state, including a same-cycle start
        if (abort) begin
            state_d  = IDLE;
            tmr_load = 1'b1;
            tmr_en   = 1'b0;
            accept   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            exp_q   <= '0;
            obs_q   <= '0;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
            mis_q   <= '0;
        end else if (abort) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
            mis_q   <= '0;
        end else begin
            if (accept) begin
                exp_q   <= expected;
                obs_q   <= '0;
                valid_q <= 1'b0;
                pass_q  <= 1'b0;
                idx_q   <= '0;
            end
            if (state_q == SAMPLE) begin
                obs_q[row_bit(idx_q)] <= dut_out;
                if (!last_row) begin
                    idx_q <= idx_q + 1'b1;
                end
            end
            if (state_q == DONE) begin
                valid_q <= 1'b1;
                pass_q  <= (obs_q == exp_q);
                mis_q   <= obs_q ^ exp_q;
            end
        end
    end

    assign stim     = (state_q == IDLE) ? 3'd0 : idx_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign valid    = valid_q;
    assign observed = obs_q;
    assign pass     = pass_q;
    assign mismatch = mis_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a result scoreboard.
// Cycle 1 is the cycle following the edge that samples start.
module tb_truth_table_sweeper;

    typedef struct {
        logic [7:0] obs;
        logic       pass;
        logic [7:0] mis;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       abort_a = 1'b0;
    logic [7:0] expected_a = '0;
    logic       dut_out_a;
    logic [2:0] stim_a;
    logic       busy_a, done_a, valid_a, pass_a;
    logic [7:0] observed_a, mismatch_a;

    logic       start_b = 1'b0;
    logic       abort_b = 1'b0;
    logic [7:0] expected_b = '0;
    logic       dut_out_b;
    logic [2:0] stim_b;
    logic       busy_b, done_b, valid_b, pass_b;
    logic [7:0] observed_b, mismatch_b;

    int   gmode_a = 0;
    int   gmode_b = 3;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;
    int   nd;
    res_t sb[$];
    res_t r;

    always #5 clk = ~clk;

    truth_table_sweeper u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .expected(expected_a), .dut_out(dut_out_a), .stim(stim_a),
        .busy(busy_a), .done(done_a), .valid(valid_a),
        .observed(observed_a), .pass(pass_a), .mismatch(mismatch_a)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .expected(expected_b), .dut_out(dut_out_b), .stim(stim_b),
        .busy(busy_b), .done(done_b), .valid(valid_b),
        .observed(observed_b), .pass(pass_b), .mismatch(mismatch_b)
    );

    // 0: 0xCA mux gate, 1: stuck-at-0, 2: AND3, 3: NOR3
    function automatic logic gate(input int mode, input logic [2:0] s);
        case (mode)
            0: return s[2] ? ~s[0] : ~s[1];
            1: return 1'b0;
            2: return &s;
            default: return ~|s;
        endcase
    endfunction

    function automatic logic [7:0] model_code(input int mode);
        logic [7:0] c;
        c = '0;
        for (int k = 0; k < 8; k++) begin
            c[7-k] = gate(mode, 3'(k));
        end
        return c;
    endfunction

    always_comb dut_out_a = gate(gmode_a, stim_a);
    always_comb dut_out_b = gate(gmode_b, stim_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic push_exp(input int mode, input logic [7:0] e);
        logic [7:0] c;
        c = model_code(mode);
        sb.push_back('{obs: c, pass: (c == e), mis: c ^ e});
    endtask

    task automatic begin_sweep(input logic [7:0] e);
        expected_a = e;
        start_a = 1'b1;
        push_exp(gmode_a, e);
        tick();
        start_a = 1'b0;
    endtask

    // Runs until done; injects a stray start in cycle inj.
    task automatic wait_done(input int inj, output int cyc, output int dn);
        cyc = 1;
        dn  = 0;
        while (done_a !== 1'b1 && cyc < 200) begin
            chk("stim_step", 32'(stim_a), 32'((cyc - 1) / 5));
            chk("busy_sweep", 32'(busy_a), 32'd1);
            start_a = (cyc == inj);
            tick();
            cyc++;
        end
        start_a = 1'b0;
        if (done_a === 1'b1) begin
            dn = 1;
            chk("busy_done", 32'(busy_a), 32'd1);
            chk("stim_done", 32'(stim_a), 32'd7);
        end
    endtask

    task automatic finish_check();
        tick();
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            r = sb.pop_front();
            chk("done_once", 32'(done_a), 32'd0);
            chk("busy_idle", 32'(busy_a), 32'd0);
            chk("valid", 32'(valid_a), 32'd1);
            chk("observed", 32'(observed_a), 32'(r.obs));
            chk("pass", 32'(pass_a), 32'(r.pass));
            chk("mismatch", 32'(mismatch_a), 32'(r.mis));
        end
    endtask

    initial begin
        #12;
        chk("rst_stim", 32'(stim_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_obs", 32'(observed_a), 32'd0);
        chk("rst_pass", 32'(pass_a), 32'd0);
        chk("rst_mis", 32'(mismatch_a), 32'd0);
        chk("rst_b_busy", 32'(busy_b), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // 0xCA gate, matching expected
        gmode_a = 0;
        begin_sweep(8'hCA);
        wait_done(-1, n, nd);
        chk("t1_latency", 32'(n), 32'd41);
        finish_check();
        chk("t1_obs_const", 32'(observed_a), 32'hCA);

        // stray start in row 3 SETTLE, then back-to-back start
        begin_sweep(8'hCA);
        wait_done(17, n, nd);
        chk("t3_latency", 32'(n), 32'd41);
        chk("t3_done_seen", 32'(nd), 32'd1);
        finish_check();
        begin_sweep(8'hCA);
        chk("t3_valid_drop", 32'(valid_a), 32'd0);
        chk("t3_busy_b2b", 32'(busy_a), 32'd1);
        wait_done(-1, n, nd);
        chk("t3b_latency", 32'(n), 32'd41);
        finish_check();

        // stuck-at-0 output
        gmode_a = 1;
        begin_sweep(8'hCA);
        wait_done(-1, n, nd);
        chk("t2_latency", 32'(n), 32'd41);
        finish_check();
        chk("t2_mis_const", 32'(mismatch_a), 32'hCA);

        // abort during row 4 SETTLE (cycle 22)
        gmode_a = 0;
        begin_sweep(8'hCA);
        repeat (21) tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        void'(sb.pop_front());
        chk("t4_stim", 32'(stim_a), 32'd0);
        chk("t4_busy", 32'(busy_a), 32'd0);
        chk("t4_done", 32'(done_a), 32'd0);
        chk("t4_valid", 32'(valid_a), 32'd0);
        chk("t4_pass", 32'(pass_a), 32'd0);
        chk("t4_mis", 32'(mismatch_a), 32'd0);
        chk("t4_partial", 32'(observed_a), 32'hC0);
        nd = 0;
        repeat (30) begin
            if (done_a === 1'b1) nd++;
            tick();
        end
        chk("t4_no_done", 32'(nd), 32'd0);

        // async reset mid-SETTLE of row 1
        begin_sweep(8'hCA);
        repeat (6) tick();
        chk("t5_partial", 32'(observed_a), 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        chk("t5_stim", 32'(stim_a), 32'd0);
        chk("t5_busy", 32'(busy_a), 32'd0);
        chk("t5_done", 32'(done_a), 32'd0);
        chk("t5_valid", 32'(valid_a), 32'd0);
        chk("t5_obs", 32'(observed_a), 32'd0);
        chk("t5_pass", 32'(pass_a), 32'd0);
        chk("t5_mis", 32'(mismatch_a), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        gmode_a = 2;
        begin_sweep(8'h01);
        wait_done(-1, n, nd);
        chk("t5_latency", 32'(n), 32'd41);
        finish_check();
        chk("t5_pass_const", 32'(pass_a), 32'd1);

        // SETTLE_CYCLES=1 instance against NOR3
        gmode_b = 3;
        expected_b = 8'h80;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 1;
        while (done_b !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("t6_latency", 32'(n), 32'd17);
        tick();
        chk("t6_valid", 32'(valid_b), 32'd1);
        chk("t6_obs", 32'(observed_b), 32'(model_code(3)));
        chk("t6_obs_const", 32'(observed_b), 32'h80);
        chk("t6_pass", 32'(pass_b), 32'd1);
        chk("t6_mis", 32'(mismatch_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
